dmem_responder: RTL

Handshaked data-memory responder servicing load/store requests from the pipeline's MEM stage. It replaces an inline, combinational data array with a clocked slave. The slave has a programmable access latency, a single outstanding transaction, and an error response for out-of-range or misaligned addresses. The MEM stage acts as initiator, and this block is the responder end of that request/response interface.

---
 rtl/dmem_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: clocked data-memory slave for the MEM stage.
// It handles one outstanding load or store at a time, with a programmable
// access latency. Out-of-range or misaligned addresses get an error response.
// Optional feature macro: DMEM_BYTE_STROBE_EN adds req_wstrb byte enables for stores.
module dmem_responder #(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
`ifdef DMEM_BYTE_STROBE_EN
  input  logic [7:0]  req_wstrb,
`endif
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int unsigned CNT_W      = $clog2(LATENCY) + 1;
  localparam int unsigned IDX_W      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [63:0] ADDR_LIMIT = 64'(DEPTH) * 64'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [CNT_W-1:0]   cnt_nxt;

  logic               lat_write;
  logic [63:0]        lat_addr;
  logic [63:0]        lat_wdata;
`ifdef DMEM_BYTE_STROBE_EN
  logic [7:0]         lat_wstrb;
`endif

  logic [63:0]        mem [DEPTH];

  logic               accept_c;
  logic               access_c;
  logic               addr_err_c;
  logic               wr_en_c;
  logic [IDX_W-1:0]   idx_c;

  // Handshake outputs decode registered state only; req_ready is held low in reset.
  assign req_ready  = (state == ST_IDLE) && reset;
  assign resp_valid = (state == ST_RESP);

  // Request acceptance, access strobe and address decode of the latched request.
  assign accept_c   = (state == ST_IDLE) && req_valid;
  assign access_c   = (state == ST_BUSY) && (cnt == '0);
  assign addr_err_c = (lat_addr[2:0] != 3'd0) || (lat_addr >= ADDR_LIMIT);
  assign idx_c      = lat_addr[IDX_W+2:3];
  assign wr_en_c    = access_c && lat_write && !addr_err_c;

  // State and latency counter registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and counter logic; the counter saturates at zero.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = ST_BUSY;
          cnt_nxt   = CNT_W'(LATENCY - 1);
        end
      end
      ST_BUSY: begin
        if (cnt != '0) begin
          cnt_nxt = cnt - CNT_W'(1);
        end else begin
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Capture the request fields at the accept handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
`ifdef DMEM_BYTE_STROBE_EN
      lat_wstrb <= '0;
`endif
    end else if (accept_c) begin
      lat_write <= req_write;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
`ifdef DMEM_BYTE_STROBE_EN
      lat_wstrb <= req_wstrb;
`endif
    end
  end

  // Register the response at the access edge; it is held until the next access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else if (access_c) begin
      resp_err   <= addr_err_c;
      resp_rdata <= (!lat_write && !addr_err_c) ? mem[idx_c] : 64'd0;
    end
  end

  // Array write; contents are deliberately not reset.
  always_ff @(posedge clock) begin
    if (wr_en_c) begin
`ifdef DMEM_BYTE_STROBE_EN
      for (int k = 0; k < 8; k++) begin
        if (lat_wstrb[k]) begin
          mem[idx_c][8*k +: 8] <= lat_wdata[8*k +: 8];
        end
      end
`else
      mem[idx_c] <= lat_wdata;
`endif
    end
  end

endmodule
